trace_arbiter: RTL and testbench

Round-robin arbiter that shares one cache simulator instance between `CORES` per-core trace streams. Each core presents a memory address with a level request. The arbiter serialises the requests onto the cache's `trace_ready`/`mem_addr` input and waits for the cache's `updated` pulse. It then acknowledges the serviced core. It sits between the per-core trace sources and the top-level cache/prefetcher instance, and includes a watchdog so a lost `updated` cannot hang the system.

---
 rtl/trace_arbiter.sv | 144 ++++++++++++++
 tb/tb_trace_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_arbiter.sv
// trace_arbiter: round-robin arbiter that serialises per-core trace requests
// onto a single cache simulator port and waits for the cache's completion pulse.
// A watchdog aborts an access whose completion never arrives.
// Optional per-core served-access counters are built when TRACE_ARB_STATS_EN is defined.
module trace_arbiter #(
    parameter int CORES   = 4,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CORES-1:0]        req,
    input  logic [CORES*ADDR_W-1:0] req_addr,
    output logic [CORES-1:0]        ack,
    output logic                    trace_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    updated,
    output logic                    busy,
    output logic [3:0]              grant_id,
    output logic                    timeout_err,
    output logic [CORES*20-1:0]     served_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [CORES-1:0] ONE_HOT0 = {{(CORES-1){1'b0}}, 1'b1};
    localparam logic [15:0]      WDOG_MAX = 16'(TIMEOUT);
    localparam logic [3:0]       LAST_ID  = 4'(CORES-1);

    state_t              r_state;
    logic [3:0]          r_ptr;
    logic [15:0]         r_wdog;

    logic                w_found;
    logic [3:0]          w_winner;
    logic [ADDR_W-1:0]   w_addr;
    logic [CORES-1:0]    w_mask;
    int                  w_pos;

    // Round-robin pick: first requesting core found searching upward from r_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_addr   = '0;
        w_mask   = '0;
        w_pos    = 0;
        for (int k = 0; k < CORES; k++) begin
            w_pos  = (int'(r_ptr) + k) % CORES;
            w_mask = ONE_HOT0 << w_pos;
            if (!w_found && ((req & w_mask) != '0)) begin
                w_found  = 1'b1;
                w_winner = w_pos[3:0];
                w_addr   = ADDR_W'(req_addr >> (w_pos * ADDR_W));
            end
        end
    end

    // Main FSM: issue strobe, completion wait with watchdog, ack pulse and pointer advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_wdog      <= '0;
            ack         <= '0;
            trace_ready <= 1'b0;
            mem_addr    <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            ack         <= '0;
            trace_ready <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        mem_addr    <= w_addr;
                        grant_id    <= w_winner;
                        trace_ready <= 1'b1;
                        busy        <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wdog <= '0;
                    if (updated) begin
                        ack     <= ONE_HOT0 << grant_id;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_wdog <= r_wdog + 16'd1;
                    if (updated) begin
                        ack     <= ONE_HOT0 << grant_id;
                        r_state <= S_DONE;
                    end else if (r_wdog == WDOG_MAX) begin
                        ack         <= ONE_HOT0 << grant_id;
                        timeout_err <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ptr   <= (grant_id == LAST_ID) ? 4'd0 : grant_id + 4'd1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef TRACE_ARB_STATS_EN
    logic [19:0] r_count [CORES];

    // Saturating completed-access counter per core, bumped once per DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CORES; i++) begin
                r_count[i] <= '0;
            end
        end else if (r_state == S_DONE) begin
            for (int i = 0; i < CORES; i++) begin
                if (grant_id == 4'(i) && r_count[i] != 20'hFFFFF) begin
                    r_count[i] <= r_count[i] + 20'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < CORES; g++) begin : g_count
        assign served_count[g*20 +: 20] = r_count[g];
    end
`else
    assign served_count = '0;
`endif

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed testbench for trace_arbiter (CORES=4, ADDR_W=32, TIMEOUT=8).
// Inputs are driven and outputs sampled on the falling edge; "cycle n" is the
// clock period following the n-th rising edge after the stimulus is applied.
module tb_trace_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] req_addr;
    logic [3:0]   ack;
    logic         trace_ready;
    logic [31:0]  mem_addr;
    logic         updated;
    logic         busy;
    logic [3:0]   grant_id;
    logic         timeout_err;
    logic [79:0]  served_count;

    int total;
    int bad;

    trace_arbiter #(
        .CORES   (4),
        .ADDR_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_addr     (req_addr),
        .ack          (ack),
        .trace_ready  (trace_ready),
        .mem_addr     (mem_addr),
        .updated      (updated),
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err),
        .served_count (served_count)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute guard against a hung simulation
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] hung");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n   = 1'b0;
        req     = '0;
        updated = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        req      = '0;
        updated  = 1'b0;
        req_addr = '0;
        tick();
        tick();
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
        total++; if (trace_ready !== 1'b0) begin bad++; $display("FAIL reset_trace_ready: got %b want 0", trace_ready); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (grant_id !== 4'd0) begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        total++; if (served_count !== 80'h0) begin bad++; $display("FAIL reset_served: got %h want 0", served_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        do_reset();
        req_addr = {32'hDEAD_0003, 32'hDEAD_0002, 32'h0000_1230, 32'hDEAD_0000};
        req      = 4'b0010;
        tick(); // cycle 1
        total++; if (trace_ready !== 1'b1) begin bad++; $display("FAIL single_trace_ready: got %b want 1", trace_ready); end
        total++; if (mem_addr !== 32'h0000_1230) begin bad++; $display("FAIL single_mem_addr: got %h want 00001230", mem_addr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        req_addr[63:32] = 32'hFFFF_0000; // late change must not reach mem_addr
        tick(); // cycle 2
        total++; if (trace_ready !== 1'b0) begin bad++; $display("FAIL single_strobe_width: got %b want 0", trace_ready); end
        tick(); // cycle 3
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL single_early_ack: got %b want 0000", ack); end
        updated = 1'b1;
        tick(); // cycle 4
        updated = 1'b0;
        req     = 4'b0000;
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL single_ack: got %b want 0010", ack); end
        total++; if (grant_id !== 4'd1) begin bad++; $display("FAIL single_grant_id: got %0d want 1", grant_id); end
        total++; if (mem_addr !== 32'h0000_1230) begin bad++; $display("FAIL single_addr_hold: got %h want 00001230", mem_addr); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL single_timeout_err: got %b want 0", timeout_err); end
        tick(); // cycle 5
        total++; if (ack !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_after: ack=%b busy=%b want 0000/0", ack, busy); end
    endtask

    task automatic test_round_robin;
        logic [3:0]  exp_id [5];
        logic [79:0] exp_served;
        int          cyc;
        exp_id[0] = 4'd0; exp_id[1] = 4'd1; exp_id[2] = 4'd2; exp_id[3] = 4'd3; exp_id[4] = 4'd0;
        do_reset();
        req_addr = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000, 32'h0000_0000};
        req      = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            cyc = 0;
            tick();
            while (trace_ready !== 1'b1 && cyc < 10) begin
                tick();
                cyc++;
            end
            total++; if (trace_ready !== 1'b1) begin bad++; $display("FAIL rr_issue%0d: trace_ready=%b want 1 within budget", n, trace_ready); end
            total++; if (grant_id !== exp_id[n]) begin bad++; $display("FAIL rr_grant%0d: got %0d want %0d", n, grant_id, exp_id[n]); end
            tick();
            tick();
            updated = 1'b1;
            tick();
            updated = 1'b0;
            if (n == 4) req = 4'b0000;
            total++; if (ack !== (4'b0001 << exp_id[n])) begin bad++; $display("FAIL rr_ack%0d: got %b want %b", n, ack, 4'b0001 << exp_id[n]); end
        end
        tick();
`ifdef TRACE_ARB_STATS_EN
        exp_served = {20'd1, 20'd1, 20'd1, 20'd2};
`else
        exp_served = 80'h0;
`endif
        total++; if (served_count !== exp_served) begin bad++; $display("FAIL rr_served: got %h want %h", served_count, exp_served); end
    endtask

    task automatic test_watchdog;
        int cyc;
        do_reset();
        req_addr = {32'h0, 32'h0, 32'h0, 32'hABCD_0000};
        req      = 4'b0001;
        tick(); // trace_ready cycle
        total++; if (trace_ready !== 1'b1) begin bad++; $display("FAIL wd_issue: got %b want 1", trace_ready); end
        cyc = 0;
        while (ack === 4'b0 && cyc < 20) begin
            tick();
            cyc++;
        end
        req = 4'b0000;
        total++; if (cyc !== 10) begin bad++; $display("FAIL wd_latency: ack after %0d cycles want 10", cyc); end
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL wd_ack: got %b want 0001", ack); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL wd_err: got %b want 1", timeout_err); end
        tick();
        total++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL wd_after: busy=%b err=%b want 0/0", busy, timeout_err); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        req_addr = {32'h0, 32'h0000_BEEF, 32'h0, 32'h0};
        req      = 4'b0100;
        tick(); // cycle 1: ISSUE
        total++; if (trace_ready !== 1'b1) begin bad++; $display("FAIL b2b_issue: got %b want 1", trace_ready); end
        updated = 1'b1;
        tick(); // cycle 2: DONE
        updated = 1'b0;
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL b2b_ack: got %b want 0100", ack); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL b2b_err: got %b want 0", timeout_err); end
        tick(); // cycle 3: IDLE, core 2 alone wins again
        total++; if (trace_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: tr=%b busy=%b want 0/0", trace_ready, busy); end
        tick(); // cycle 4: second issue
        total++; if (trace_ready !== 1'b1 || grant_id !== 4'd2) begin bad++; $display("FAIL b2b_reissue: tr=%b id=%0d want 1/2", trace_ready, grant_id); end
        updated = 1'b1;
        req     = 4'b0000;
        tick(); // cycle 5
        updated = 1'b0;
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL b2b_ack2: got %b want 0100", ack); end
        tick();
    endtask

    task automatic test_reset_mid_wait;
        logic [3:0] ack_seen;
        do_reset();
        req_addr = {32'h0, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        req      = 4'b0010;
        tick(); // ISSUE core 1
        updated = 1'b1;
        tick(); // DONE, ptr -> 2
        updated = 1'b0;
        req     = 4'b0100;
        tick(); // IDLE
        tick(); // ISSUE core 2
        total++; if (grant_id !== 4'd2) begin bad++; $display("FAIL rst_pre_grant: got %0d want 2", grant_id); end
        tick(); // WAIT
        rst_n = 1'b0;
        tick();
        total++; if ({ack, trace_ready, busy, timeout_err} !== 7'b0) begin bad++; $display("FAIL rst_mid_ctrl: ack=%b tr=%b busy=%b err=%b want all 0", ack, trace_ready, busy, timeout_err); end
        total++; if (mem_addr !== 32'h0 || grant_id !== 4'd0) begin bad++; $display("FAIL rst_mid_data: addr=%h id=%0d want 0/0", mem_addr, grant_id); end
        rst_n    = 1'b1;
        req      = 4'b0000;
        ack_seen = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            ack_seen = ack_seen | ack;
        end
        total++; if (ack_seen !== 4'b0) begin bad++; $display("FAIL rst_no_ack: got %b want 0000", ack_seen); end
        req = 4'b1111;
        tick();
        total++; if (trace_ready !== 1'b1 || grant_id !== 4'd0) begin bad++; $display("FAIL rst_ptr: tr=%b id=%0d want 1/0", trace_ready, grant_id); end
        updated = 1'b1;
        req     = 4'b0000;
        tick();
        updated = 1'b0;
        tick();
    endtask

    task automatic test_drop_and_stray;
        logic [79:0] exp_served;
        do_reset();
        updated = 1'b1;
        tick();
        updated = 1'b0;
        tick();
        total++; if (ack !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL stray_ack: ack=%b busy=%b want 0000/0", ack, busy); end
        total++; if (served_count !== 80'h0) begin bad++; $display("FAIL stray_served: got %h want 0", served_count); end
        req_addr = {32'h3030_3030, 32'h0, 32'h0, 32'h0};
        req      = 4'b1000;
        tick(); // ISSUE
        req = 4'b0000;
        total++; if (mem_addr !== 32'h3030_3030) begin bad++; $display("FAIL drop_addr: got %h want 30303030", mem_addr); end
        tick(); // WAIT
        updated = 1'b1;
        tick(); // DONE
        updated = 1'b0;
        total++; if (ack !== 4'b1000) begin bad++; $display("FAIL drop_ack: got %b want 1000", ack); end
        tick();
`ifdef TRACE_ARB_STATS_EN
        exp_served = {20'd1, 60'h0};
`else
        exp_served = 80'h0;
`endif
        total++; if (served_count !== exp_served) begin bad++; $display("FAIL drop_served: got %h want %h", served_count, exp_served); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        updated  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_watchdog();
        test_back_to_back();
        test_reset_mid_wait();
        test_drop_and_stray();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
